// File: rtl/instr_bus_responder.sv
// -----------------------------------------------------------------------------
// instr_bus_responder
//
// Responder end of the instruction-fetch bus. Accepts one fetch request at a
// time, issues a level read request to a variable-latency backing memory and
// returns one 32-bit word per request with a single-cycle response strobe.
// Fetch redirects (flush_bus_i) discard the in-flight word, and a timeout
// covers a memory that never acknowledges.
//
// Optional feature (macro LINE_BUFFER_EN): a single-word line buffer that
// serves repeat fetches of the same word in one cycle without a memory access.
// invalidate_i clears it (fence.i). Without the macro invalidate_i is unused.
//
// Parameters:
//   TIMEOUT_CYCLES  WAIT/DRAIN cycles before the access is abandoned
//   NOP_WORD        data returned on a timeout
//   ADDR_WIDTH      fetch / memory address width
//
// Ports:
//   clk                     core clock, rising edge
//   rst                     asynchronous active-high reset
//   instruction_request_i   fetch wants the word at instruction_addr_i
//   flush_bus_i             fetch redirected; in-flight word is stale
//   instruction_addr_i      fetch PC (may be halfword aligned)
//   instruction_response_o  one-cycle pulse, instruction_data_o valid
//   instruction_data_o      word at the word-aligned captured address
//   invalidate_i            line buffer invalidate
//   mem_rd_o                level read request to memory
//   mem_addr_o              word-aligned read address
//   mem_ack_i               memory data valid this cycle
//   mem_data_i              memory read data
//   bus_error_o             one-cycle pulse on timeout
// -----------------------------------------------------------------------------
module instr_bus_responder #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] NOP_WORD       = 32'h00000013,
  parameter int          ADDR_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instruction_request_i,
  input  logic                  flush_bus_i,
  input  logic [ADDR_WIDTH-1:0] instruction_addr_i,
  output logic                  instruction_response_o,
  output logic [31:0]           instruction_data_o,
  input  logic                  invalidate_i,
  output logic                  mem_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ack_i,
  input  logic [31:0]           mem_data_i,
  output logic                  bus_error_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    mem_rd_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [31:0]             data_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    bus_err_q;

  logic                    timeout;
  logic                    busy;
  logic                    take_req;
  logic                    take_hit;
  logic                    take_miss;
  logic                    ack_keep;
  logic                    tmo_fire;
  logic                    tmo_nop;
  logic                    rd_release;
  logic                    lb_hit;
  logic [31:0]             lb_data;

  // The low two address bits never reach memory; fetch picks halves itself.
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^instruction_addr_i[1:0];

  // The counter counts WAIT/DRAIN cycles without an ack since the request
  // was accepted; the access is abandoned on the cycle it would reach the limit.
  assign cnt_inc = cnt_q + 1'b1;
  assign timeout = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  assign busy       = (state_q == WAIT) || (state_q == DRAIN);
  assign take_req   = (state_q == IDLE) && instruction_request_i;
  assign take_hit   = take_req && lb_hit;
  assign take_miss  = take_req && !lb_hit;
  assign ack_keep   = (state_q == WAIT) && mem_ack_i && !flush_bus_i;
  assign tmo_fire   = busy && !mem_ack_i && timeout;
  assign tmo_nop    = (state_q == WAIT) && !mem_ack_i && timeout && !flush_bus_i;
  assign rd_release = busy && (mem_ack_i || timeout);

`ifdef LINE_BUFFER_EN
  logic                  lb_valid_q;
  logic [ADDR_WIDTH-3:0] lb_tag_q;
  logic [31:0]           lb_data_q;

  // A same-cycle invalidate wins over a hit so fence.i is never bypassed.
  assign lb_hit  = lb_valid_q && !invalidate_i &&
                   (lb_tag_q == instruction_addr_i[ADDR_WIDTH-1:2]);
  assign lb_data = lb_data_q;

  // Filled on every kept memory word; timeout NOP data is never captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lb_valid_q <= 1'b0;
      lb_tag_q   <= '0;
      lb_data_q  <= '0;
    end else if (invalidate_i) begin
      lb_valid_q <= 1'b0;
    end else if (ack_keep) begin
      lb_valid_q <= 1'b1;
      lb_tag_q   <= mem_addr_q[ADDR_WIDTH-1:2];
      lb_data_q  <= mem_data_i;
    end
  end
`else
  logic unused_invalidate;
  assign unused_invalidate = invalidate_i;
  assign lb_hit  = 1'b0;
  assign lb_data = '0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (instruction_request_i) state_d = lb_hit ? RESP : WAIT;
      end
      WAIT: begin
        if (mem_ack_i)        state_d = flush_bus_i ? IDLE : RESP;
        else if (timeout)     state_d = flush_bus_i ? IDLE : RESP;
        else if (flush_bus_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (mem_ack_i || timeout) state_d = IDLE;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    instruction_response_o = (state_q == RESP);
  end

  assign mem_rd_o           = mem_rd_q;
  assign mem_addr_o         = mem_addr_q;
  assign instruction_data_o = data_q;
  assign bus_error_o        = bus_err_q;

  // Request, address, data and timeout registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      data_q     <= NOP_WORD;
      cnt_q      <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      bus_err_q <= tmo_fire;

      if (take_miss) begin
        mem_rd_q   <= 1'b1;
        mem_addr_q <= {instruction_addr_i[ADDR_WIDTH-1:2], 2'b00};
      end else if (rd_release) begin
        mem_rd_q <= 1'b0;
      end

      if (take_miss)               cnt_q <= '0;
      else if (busy && !mem_ack_i) cnt_q <= cnt_inc;

      // Data only changes when a response is about to be presented.
      if (ack_keep)      data_q <= mem_data_i;
      else if (tmo_nop)  data_q <= NOP_WORD;
      else if (take_hit) data_q <= lb_data;
    end
  end

endmodule

// File: tb/tb_instr_bus_responder.sv
module tb_instr_bus_responder;

  localparam int          TO  = 64;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instruction_request_i = 1'b0;
  logic        flush_bus_i = 1'b0;
  logic [31:0] instruction_addr_i = '0;
  logic        instruction_response_o;
  logic [31:0] instruction_data_o;
  logic        invalidate_i = 1'b0;
  logic        mem_rd_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_data_i = '0;
  logic        bus_error_o;

  always #5 clk = ~clk;

  instr_bus_responder #(
    .TIMEOUT_CYCLES(TO),
    .NOP_WORD(NOP),
    .ADDR_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .instruction_request_i(instruction_request_i),
    .flush_bus_i(flush_bus_i),
    .instruction_addr_i(instruction_addr_i),
    .instruction_response_o(instruction_response_o),
    .instruction_data_o(instruction_data_o),
    .invalidate_i(invalidate_i),
    .mem_rd_o(mem_rd_o),
    .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i),
    .mem_data_i(mem_data_i),
    .bus_error_o(bus_error_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: last word presented to fetch and the line buffer contents.
  logic [31:0] last_data;
  bit          lb_valid = 0;
  logic [29:0] lb_tag = '0;
  logic [31:0] lb_data = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] wa);
    if (wa == 32'h100) return 32'hDEADBEEF;
    return (wa * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One fetch transaction. Cycle index i counts clock cycles after the edge
  // that samples the request. The bench plays memory: it acks at index ack_at
  // (>= TO means never) and optionally flushes at index flush_at (-1 = none).
  task automatic fetch(input logic [31:0] addr, input int ack_at, input int flush_at,
                       input string tag);
    logic [31:0] wa;
    logic [31:0] exp_data;
    bit          hit, acked, dropped;
    int          resp_idx, err_idx, rd_last, last_idx;
    wa  = {addr[31:2], 2'b00};
    hit = 0;
`ifdef LINE_BUFFER_EN
    hit = lb_valid && (lb_tag == addr[31:2]);
`endif
    acked    = ack_at < TO;
    dropped  = (flush_at >= 0) && (!acked || flush_at <= ack_at);
    resp_idx = -1;
    err_idx  = -1;
    rd_last  = -1;
    exp_data = last_data;
    if (hit) begin
      resp_idx = 0;
      exp_data = lb_data;
      last_idx = 0;
    end else if (acked) begin
      rd_last  = ack_at;
      last_idx = ack_at + 1;
      if (!dropped) begin
        resp_idx = ack_at + 1;
        exp_data = mem_word(wa);
      end
    end else begin
      rd_last  = TO - 1;
      err_idx  = TO;
      last_idx = TO;
      if (!dropped) begin
        resp_idx = TO;
        exp_data = NOP;
      end
    end

    @(negedge clk);
    instruction_request_i = 1'b1;
    instruction_addr_i    = addr;
    for (int i = 0; i <= last_idx + 1; i++) begin
      @(negedge clk);
      instruction_request_i = 1'b0;
      instruction_addr_i    = $urandom;
      chk({tag, ":rd"}, {31'b0, mem_rd_o}, {31'b0, (i <= rd_last)});
      if (i <= rd_last) chk({tag, ":addr"}, mem_addr_o, wa);
      chk({tag, ":resp"}, {31'b0, instruction_response_o}, {31'b0, (i == resp_idx)});
      chk({tag, ":err"}, {31'b0, bus_error_o}, {31'b0, (i == err_idx)});
      chk({tag, ":data"}, instruction_data_o,
          (resp_idx >= 0 && i >= resp_idx) ? exp_data : last_data);
      if (!hit) begin
        mem_ack_i   = (i == ack_at);
        mem_data_i  = (i == ack_at) ? mem_word(wa) : $urandom;
        flush_bus_i = (i == flush_at);
      end
    end
    mem_ack_i   = 1'b0;
    flush_bus_i = 1'b0;
    last_data   = exp_data;
    if (!hit && acked && !dropped) begin
      lb_valid = 1;
      lb_tag   = addr[31:2];
      lb_data  = mem_word(wa);
    end
  endtask

  task automatic invalidate();
    @(negedge clk);
    invalidate_i = 1'b1;
    @(negedge clk);
    invalidate_i = 1'b0;
    lb_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          ack_at, flush_at;

    // Reset state
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst:resp", {31'b0, instruction_response_o}, 32'd0);
    chk("rst:data", instruction_data_o, NOP);
    chk("rst:rd", {31'b0, mem_rd_o}, 32'd0);
    chk("rst:addr", mem_addr_o, 32'd0);
    chk("rst:err", {31'b0, bus_error_o}, 32'd0);
    rst = 1'b0;
    last_data = NOP;
    @(negedge clk);

    // Basic fetch, halfword-aligned fetch, minimum latency
    fetch(32'h100, 3, -1, "tp1");
    fetch(32'h102, 0, -1, "tp2");
    // Flush one cycle after the request, ack later, then a clean fetch
    fetch(32'h200, 3, 0, "tp3");
    fetch(32'h300, 1, -1, "tp3b");
    // Flush coincident with ack, then an immediate follow-up fetch
    fetch(32'h600, 2, 2, "coinc");
    fetch(32'h604, 0, -1, "coincb");
    // Dead memory: timeout in WAIT, then in DRAIN
    fetch(32'h700, 1000, -1, "tmo");
    fetch(32'h800, 1000, 1, "dtmo");
    fetch(32'h900, 1, -1, "post_tmo");
    // Repeat fetch (line buffer hit when built with it), invalidate, refetch
    fetch(32'h400, 1, -1, "lb1");
    fetch(32'h400, 1, -1, "lb2");
    invalidate();
    fetch(32'h402, 1, -1, "lb3");

    // Asynchronous reset in the middle of a transaction
    @(negedge clk);
    instruction_request_i = 1'b1;
    instruction_addr_i    = 32'h500;
    @(negedge clk);
    instruction_request_i = 1'b0;
    chk("mrst:rd_before", {31'b0, mem_rd_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mrst:rd_async", {31'b0, mem_rd_o}, 32'd0);
    chk("mrst:addr_async", mem_addr_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_data = NOP;
    lb_valid = 0;
    @(negedge clk);
    mem_ack_i  = 1'b1;
    mem_data_i = 32'hCAFEF00D;
    @(negedge clk);
    mem_ack_i = 1'b0;
    chk("mrst:stray_resp", {31'b0, instruction_response_o}, 32'd0);
    chk("mrst:stray_rd", {31'b0, mem_rd_o}, 32'd0);
    @(negedge clk);
    chk("mrst:stray_resp2", {31'b0, instruction_response_o}, 32'd0);
    chk("mrst:data", instruction_data_o, NOP);

    // Randomized fetches over a small address pool
    for (int n = 0; n < 24; n++) begin
      a      = 32'h1000 + ($urandom_range(0, 7) << 1);
      ack_at = ($urandom_range(0, 9) == 0) ? 1000 : $urandom_range(0, 5);
      if ($urandom_range(0, 3) == 0)
        flush_at = (ack_at >= TO) ? $urandom_range(0, 5) : $urandom_range(0, ack_at);
      else
        flush_at = -1;
      fetch(a, ack_at, flush_at, "rnd");
      if ($urandom_range(0, 5) == 0) invalidate();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_bus_responder.md
Name: instr_bus_responder

Overview:
- Responder end of the instruction-fetch bus: accepts fetch requests, addresses and flushes, and returns one 32-bit word per request with a single-cycle response strobe.
- Sits between the fetch/decode stage and a variable-latency backing memory (BRAM/ROM/bus bridge) that uses a level request / ack handshake.
- Handles fetch redirects by discarding in-flight responses, and covers dead memory with a timeout.

Parameters:
- TIMEOUT_CYCLES, 64, WAIT/DRAIN cycles before abort; counter width $clog2(TIMEOUT_CYCLES+1).
- NOP_WORD, 32'h00000013, data returned on timeout.
- ADDR_WIDTH, 32, fetch/memory address width.

Ports:
- clk  in  1  core clock, all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- instruction_request_i  in  1  fetch wants a word at instruction_addr_i.
- flush_bus_i  in  1  fetch redirected; the in-flight word is stale.
- instruction_addr_i  in  ADDR_WIDTH  fetch PC; may be halfword-aligned.
- instruction_response_o  out  1  one-cycle pulse; instruction_data_o valid.
- instruction_data_o  out  32  word at {captured_addr[31:2],2'b00}.
- invalidate_i  in  1  line-buffer invalidate (fence.i); ignored without macro.
- mem_rd_o  out  1  level read request to memory.
- mem_addr_o  out  ADDR_WIDTH  word-aligned read address.
- mem_ack_i  in  1  memory data valid this cycle.
- mem_data_i  in  32  memory read data.
- bus_error_o  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (async, any state): state=IDLE; instruction_response_o=0; instruction_data_o=NOP_WORD; mem_rd_o=0; mem_addr_o=0; bus_error_o=0; timeout counter=0; line buffer invalid. Reset mid-transaction drops it; any later mem_ack_i is ignored in IDLE.
- States: IDLE, WAIT, DRAIN, RESP.
- IDLE: if instruction_request_i, capture {addr[31:2],2'b00} into mem_addr_o, set mem_rd_o=1, clear counter, go WAIT. flush_bus_i is ignored in IDLE.
- WAIT: mem_rd_o held high and mem_addr_o stable until ack.
  - mem_ack_i & !flush_bus_i: register mem_data_i into instruction_data_o, drop mem_rd_o, go RESP.
  - mem_ack_i & flush_bus_i (same cycle): discard data, drop mem_rd_o, go IDLE, no response.
  - flush_bus_i & !mem_ack_i: go DRAIN; mem_rd_o stays high.
  - Counter reaches TIMEOUT_CYCLES: instruction_data_o=NOP_WORD, pulse bus_error_o, drop mem_rd_o, go RESP.
- DRAIN: wait for mem_ack_i, discard data, go IDLE. Further flushes are no-ops. On timeout, pulse bus_error_o and go IDLE, no response.
- RESP: instruction_response_o=1 for exactly this cycle, then IDLE. The next request is sampled in IDLE the following cycle, so fetch presents the new PC there.
- Latency: request sampled at edge 0; earliest ack in cycle 1; response high in cycle 2. Minimum request-to-response is 2 cycles; throughput is 1 word per 3 cycles without the line buffer.
- The halfword bit of the address is never used; fetch selects halves itself.
- instruction_data_o holds its value outside RESP.

Optional Feature:
- Macro LINE_BUFFER_EN adds a single-word buffer (tag[ADDR_WIDTH-1:2], data, valid), filled on every accepted WAIT ack.
- IDLE with instruction_request_i and a tag hit: no memory access; data loaded and state goes directly to RESP (1-cycle latency).
- invalidate_i clears valid in any state. A fill in the same cycle as invalidate_i is not kept.
- Timeout NOP data is never buffered.
- Without the macro: no buffer exists, invalidate_i is unused, and every request goes through WAIT.

Test Plan:
- Reset, then request addr 0x100, memory acks after 3 cycles with 0xDEADBEEF -> mem_addr_o=0x100, one response pulse with data 0xDEADBEEF, mem_rd_o low afterwards.
- Request addr 0x102 -> mem_addr_o=0x100; response data equals word at 0x100.
- Request 0x200, flush_bus_i at cycle 1, ack at cycle 4 -> no response; next request 0x300 returns word 0x300 only.
- Flush coincident with ack -> data dropped, state IDLE next cycle, instruction_response_o never high.
- No ack for 64 cycles -> bus_error_o pulse, response with 0x00000013, mem_rd_o deasserted.
- LINE_BUFFER_EN: two requests to 0x400 -> second has no mem_rd_o and 1-cycle response; after invalidate_i, third request to 0x400 hits memory again.
